// File: rtl/cal_pkg.sv
// Shared calculator definitions: keypad codes, operand-entry state encoding and
// a digit classifier used by operand_entry and the ALU control path.
package cal_pkg;

    localparam logic [3:0] KEY_CLR   = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_SIGN  = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2
    } cal_state_e;

    function automatic logic is_digit(input logic [3:0] code, input int radix);
        return ({28'd0, code} < 32'(radix));
    endfunction

endpackage

// File: rtl/key_edge.sv
// Button synchroniser: STAGES-deep flop chain on an asynchronous level, followed by
// a registered one-cycle pulse on each synchronised rising edge.
module key_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    // Bit STAGES holds the previous synchronised level for edge detection.
    logic [STAGES:0] sync_q, sync_d;
    logic            pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[STAGES-1:0], din};
        pulse_d = sync_q[STAGES-1] & ~sync_q[STAGES];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/operand_entry.sv
// Keypad operand accumulator: builds a multi-digit operand from key events and hands it
// off via op_valid/op_ready. Define OPERAND_ENTRY_SIGN_EN to enable the SIGN key.
module operand_entry
    import cal_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MAX_DIGITS  = 8,
    parameter int RADIX       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              key_strobe,
    input  logic [3:0]                        key_code,
    input  logic                              op_ready,
    output logic                              op_valid,
    output logic [WIDTH-1:0]                  value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_cnt,
    output logic                              overflow
);

    localparam int CW = $clog2(MAX_DIGITS+1);
    localparam int EW = WIDTH + 4;

`ifdef OPERAND_ENTRY_SIGN_EN
    localparam bit SIGN_EN = 1'b1;
`else
    localparam bit SIGN_EN = 1'b0;
`endif

    localparam logic [EW-1:0] MAXMAG  = SIGN_EN ? ((EW'(1) << (WIDTH-1)) - EW'(1))
                                                : ((EW'(1) << WIDTH) - EW'(1));
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    cal_state_e       state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             key_evt;
    logic             key_is_digit;
    logic [EW-1:0]    next_mag;

    key_edge #(
        .STAGES (SYNC_STAGES)
    ) u_key_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (key_strobe),
        .pulse (key_evt)
    );

    always_comb begin
        state_d      = state_q;
        mag_d        = mag_q;
        cnt_d        = cnt_q;
        neg_d        = neg_q;
        ovf_d        = ovf_q;
        key_is_digit = is_digit(key_code, RADIX);
        // Extra 4 bits keep the multiply-add exact so the range compare sees true overflow.
        next_mag     = EW'(mag_q) * EW'(RADIX) + EW'(key_code);

        case (state_q)
            ST_IDLE: begin
                if (key_evt) begin
                    if (key_is_digit) begin
                        if (key_code != 4'd0) begin
                            mag_d   = WIDTH'(key_code);
                            cnt_d   = CW'(1);
                            state_d = ST_ENTRY;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        state_d = ST_DONE;
                    end else if (key_code == KEY_CLR) begin
                        ovf_d = 1'b0;
                    end else if (SIGN_EN && key_code == KEY_SIGN) begin
                        neg_d = ~neg_q;
                    end
                end
            end
            ST_ENTRY: begin
                if (key_evt) begin
                    if (key_is_digit) begin
                        if (cnt_q == MAX_CNT || next_mag > MAXMAG) begin
                            ovf_d = 1'b1;
                        end else begin
                            mag_d = next_mag[WIDTH-1:0];
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (key_code == KEY_BKSP) begin
                        mag_d = mag_q / WIDTH'(RADIX);
                        cnt_d = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end else if (key_code == KEY_CLR) begin
                        mag_d   = '0;
                        cnt_d   = '0;
                        neg_d   = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else if (SIGN_EN && key_code == KEY_SIGN) begin
                        neg_d = ~neg_q;
                    end else if (key_code == KEY_ENTER) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Key events are deliberately ignored here, even on the handoff cycle.
                if (op_ready) begin
                    mag_d   = '0;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        value = neg_q ? (WIDTH'(0) - mag_q) : mag_q;
    end

    assign op_valid  = (state_q == ST_DONE);
    assign digit_cnt = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_operand_entry.sv
// Randomised scoreboard bench for operand_entry: a 32-bit and an 8-bit instance share
// one keypad stream; a digit-list model predicts each handed-off operand.
module tb_operand_entry;
    import cal_pkg::*;

    localparam int S      = 2;
    localparam int RADIX  = 10;
    localparam int MAXD   = 8;

`ifdef OPERAND_ENTRY_SIGN_EN
    localparam bit SIGN_ON = 1'b1;
`else
    localparam bit SIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_strobe = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        op_ready = 1'b0;

    logic        op_valid0, ovf0;
    logic [31:0] value0;
    logic [3:0]  cnt0;
    logic        op_valid1, ovf1;
    logic [7:0]  value1;
    logic [3:0]  cnt1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    operand_entry #(.WIDTH(32), .MAX_DIGITS(MAXD), .RADIX(RADIX), .SYNC_STAGES(S)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .key_strobe(key_strobe), .key_code(key_code),
        .op_ready(op_ready), .op_valid(op_valid0), .value(value0),
        .digit_cnt(cnt0), .overflow(ovf0)
    );

    operand_entry #(.WIDTH(8), .MAX_DIGITS(MAXD), .RADIX(RADIX), .SYNC_STAGES(S)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .key_strobe(key_strobe), .key_code(key_code),
        .op_ready(op_ready), .op_valid(op_valid1), .value(value1),
        .digit_cnt(cnt1), .overflow(ovf1)
    );

    // Reference model: each instance keeps the list of accepted digits.
    typedef struct packed {
        logic [63:0] value;
        int          cnt;
        bit          ovf;
    } exp_t;

    int unsigned digits [2][16];
    int          ndig   [2];
    bit          m_neg  [2];
    bit          m_ovf  [2];
    bit          m_done [2];
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];

    function automatic int m_width(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic logic [63:0] mag_of(input int i);
        logic [63:0] v = 64'd0;
        for (int j = 0; j < ndig[i]; j++) v = v * RADIX + 64'(digits[i][j]);
        return v;
    endfunction

    function automatic logic [63:0] maxmag(input int i);
        int w = m_width(i);
        return SIGN_ON ? ((64'd1 << (w - 1)) - 64'd1) : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic model_key(input int k);
        exp_t        e;
        logic [63:0] mask;
        for (int i = 0; i < 2; i++) begin
            if (m_done[i]) continue;
            if (k < RADIX) begin
                if (ndig[i] == 0 && k == 0) begin
                end else if (ndig[i] == MAXD || mag_of(i) * RADIX + 64'(k) > maxmag(i)) begin
                    m_ovf[i] = 1'b1;
                end else begin
                    digits[i][ndig[i]] = k;
                    ndig[i]++;
                end
            end else if (k == int'(KEY_CLR)) begin
                if (ndig[i] != 0) begin
                    ndig[i]  = 0;
                    m_neg[i] = 1'b0;
                end
                m_ovf[i] = 1'b0;
            end else if (k == int'(KEY_BKSP)) begin
                if (ndig[i] > 0) ndig[i]--;
            end else if (k == int'(KEY_SIGN) && SIGN_ON) begin
                m_neg[i] = ~m_neg[i];
            end else if (k == int'(KEY_ENTER)) begin
                m_done[i] = 1'b1;
                mask    = (64'd1 << m_width(i)) - 64'd1;
                e.value = (m_neg[i] ? (64'd0 - mag_of(i)) : mag_of(i)) & mask;
                e.cnt   = ndig[i];
                e.ovf   = m_ovf[i];
                if (i == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
            end
        end
    endtask

    task automatic model_clear(input bit only_done);
        for (int i = 0; i < 2; i++) begin
            if (!only_done || m_done[i]) begin
                ndig[i]   = 0;
                m_neg[i]  = 1'b0;
                m_ovf[i]  = 1'b0;
                m_done[i] = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each operand at the handoff cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && op_ready && op_valid0) begin
                if (exp_q0.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL d32 unexpected operand: got 0x%0h, expected none", value0);
                end else begin
                    e = exp_q0.pop_front();
                    check("d32 value", 64'(value0), e.value);
                    check("d32 digit_cnt", 64'(cnt0), 64'(e.cnt));
                    check("d32 overflow", 64'(ovf0), 64'(e.ovf));
                    $display("d32 operand value=0x%0h cnt=%0d ovf=%0d", value0, cnt0, ovf0);
                end
            end
            if (rst_n && op_ready && op_valid1) begin
                if (exp_q1.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL d8 unexpected operand: got 0x%0h, expected none", value1);
                end else begin
                    e = exp_q1.pop_front();
                    check("d8 value", 64'(value1), e.value);
                    check("d8 digit_cnt", 64'(cnt1), 64'(e.cnt));
                    check("d8 overflow", 64'(ovf1), 64'(e.ovf));
                    $display("d8 operand value=0x%0h cnt=%0d ovf=%0d", value1, cnt1, ovf1);
                end
            end
        end
    end

    task automatic press(input int k);
        key_code = k[3:0];
        @(posedge clk); #1;
        key_strobe = 1'b1;
        model_key(k);
        repeat (4) @(posedge clk);
        #1 key_strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " op_valid32"}, 64'(op_valid0), 64'd0);
        check({tag, " value32"},    64'(value0),    64'd0);
        check({tag, " cnt32"},      64'(cnt0),      64'd0);
        check({tag, " op_valid8"},  64'(op_valid1), 64'd0);
        check({tag, " value8"},     64'(value1),    64'd0);
    endtask

    task automatic finish_op(input int hold);
        int held = 0;
        check("op_valid32 after ENTER", 64'(op_valid0), 64'd1);
        check("op_valid8 after ENTER",  64'(op_valid1), 64'd1);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (op_valid0 && op_valid1) held++;
        end
        check("op_valid hold", 64'(held), 64'(hold));
        @(posedge clk); #1 op_ready = 1'b1;
        @(posedge clk); #1 op_ready = 1'b0;
        model_clear(1'b1);
        @(negedge clk);
        check_idle("post-accept");
    endtask

    task automatic enter_seq(input int k0, input int k1, input int k2, input int n);
        if (n > 0) press(k0);
        if (n > 1) press(k1);
        if (n > 2) press(k2);
        press(int'(KEY_ENTER));
        finish_op(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n, r, k;
        model_clear(1'b0);
        #1;
        check_idle("reset");
        check("reset ovf32", 64'(ovf0), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1,2,3,ENTER with op_ready held low for 20 cycles
        press(1); press(2); press(3); press(int'(KEY_ENTER));
        finish_op(20);
        // leading-zero suppression
        enter_seq(0, 0, 7, 3);
        // nine 9s: digit-count limit (32-bit) and range limit (8-bit)
        for (int i = 0; i < 9; i++) press(9);
        press(int'(KEY_ENTER));
        finish_op(2);
        for (int i = 0; i < 9; i++) press(9);
        press(int'(KEY_CLR));
        press(int'(KEY_ENTER));
        finish_op(1);
        enter_seq(2, 5, 6, 3);
        enter_seq(4, 5, int'(KEY_BKSP), 3);
        enter_seq(7, int'(KEY_SIGN), 0, 2);

        // key event coincident with op_ready in DONE must be dropped
        press(1); press(2); press(int'(KEY_ENTER));
        key_code = 4'd5;
        @(posedge clk); #1 key_strobe = 1'b1;
        model_key(5);
        repeat (S + 1) @(posedge clk);
        #1 op_ready = 1'b1;
        @(posedge clk); #1 op_ready = 1'b0;
        model_clear(1'b1);
        repeat (3) @(posedge clk);
        #1 key_strobe = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_idle("coincident key");

        // asynchronous reset mid-entry
        press(3); press(4);
        for (int i = 0; i < 9; i++) press(9);
        #3 rst_n = 1'b0;
        #1;
        check_idle("async reset");
        check("async reset ovf32", 64'(ovf0), 64'd0);
        check("async reset ovf8",  64'(ovf1), 64'd0);
        model_clear(1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // randomised operands
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 12);
            for (int j = 0; j < n; j++) begin
                r = $urandom_range(0, 19);
                if (r < 12)       k = $urandom_range(0, 9);
                else if (r < 15)  k = 9;
                else if (r == 15) k = int'(KEY_BKSP);
                else if (r == 16) k = int'(KEY_CLR);
                else if (r == 17) k = int'(KEY_SIGN);
                else if (r == 18) k = $urandom_range(13, 14);
                else              k = int'(KEY_ENTER);
                press(k);
            end
            press(int'(KEY_ENTER));
            finish_op($urandom_range(0, 5));
        end

        check("d32 pending operands", 64'(exp_q0.size()), 64'd0);
        check("d8 pending operands",  64'(exp_q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
